// File: rtl/arbitro_vc.sv
// Read-side arbiter for two virtual-channel FIFOs: strict VC0 priority with a VC1 starvation
// guard, routing each popped word to D0 or D1 by its destination bit, two-cycle pop-to-push.
module arbitro_vc #(
    parameter int unsigned DATA_SIZE  = 10,
    parameter int unsigned DEST_BIT   = 8,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 5
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic [DATA_SIZE-1:0] data_vc0,
    input  logic [DATA_SIZE-1:0] data_vc1,
    input  logic                 vc0_empty,
    input  logic                 vc1_empty,
    input  logic                 d0_pause,
    input  logic                 d1_pause,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic                 push_d0,
    output logic                 push_d1,
    output logic [DATA_SIZE-1:0] data_out,
    output logic [CNT_W-1:0]     cnt_d0,
    output logic [CNT_W-1:0]     cnt_d1,
    output logic                 idle
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {StIdle, StActive} state_e;

    state_e               state_q, state_d;
    logic [SW-1:0]        starve_q, starve_d;
    logic                 rd_vld_q, rd_vld_d;
    logic                 rd_src_q, rd_src_d;
    logic                 push_d0_q, push_d0_d;
    logic                 push_d1_q, push_d1_d;
    logic [DATA_SIZE-1:0] data_out_q, data_out_d;
    logic [CNT_W-1:0]     cnt_d0_q, cnt_d0_d;
    logic [CNT_W-1:0]     cnt_d1_q, cnt_d1_d;

    logic                 go;
    logic                 grant0, grant1;
    logic [DATA_SIZE-1:0] rd_word;

    always_comb begin
        go     = !d0_pause && !d1_pause;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StActive) begin
            grant1 = go && !vc1_empty && (vc0_empty || (starve_q == SW'(STARVE_MAX)));
            grant0 = go && !vc0_empty && !grant1;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (grant1 || vc1_empty) begin
            starve_d = '0;
        end else if (grant0 && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Stage 1 remembers which FIFO was popped; its read data arrives one cycle later.
    always_comb begin
        rd_vld_d   = grant0 || grant1;
        rd_src_d   = grant1;
        rd_word    = rd_src_q ? data_vc1 : data_vc0;
        push_d0_d  = rd_vld_q && !rd_word[DEST_BIT];
        push_d1_d  = rd_vld_q && rd_word[DEST_BIT];
        data_out_d = rd_vld_q ? rd_word : data_out_q;
        cnt_d0_d   = cnt_d0_q + CNT_W'(push_d0_d);
        cnt_d1_d   = cnt_d1_q + CNT_W'(push_d1_d);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!vc0_empty || !vc1_empty) state_d = StActive;
            end
            StActive: begin
                if (vc0_empty && vc1_empty && !rd_vld_q && !push_d0_q && !push_d1_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= StIdle;
            starve_q   <= '0;
            rd_vld_q   <= 1'b0;
            rd_src_q   <= 1'b0;
            push_d0_q  <= 1'b0;
            push_d1_q  <= 1'b0;
            data_out_q <= '0;
            cnt_d0_q   <= '0;
            cnt_d1_q   <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rd_vld_q   <= rd_vld_d;
            rd_src_q   <= rd_src_d;
            push_d0_q  <= push_d0_d;
            push_d1_q  <= push_d1_d;
            data_out_q <= data_out_d;
            cnt_d0_q   <= cnt_d0_d;
            cnt_d1_q   <= cnt_d1_d;
        end
    end

    assign pop_vc0  = grant0;
    assign pop_vc1  = grant1;
    assign push_d0  = push_d0_q;
    assign push_d1  = push_d1_q;
    assign data_out = data_out_q;
    assign cnt_d0   = cnt_d0_q;
    assign cnt_d1   = cnt_d1_q;
    assign idle     = (state_q == StIdle);

endmodule

// File: tb/tb_arbitro_vc.sv
// Scoreboard bench for arbitro_vc: behavioural VC FIFOs feed the DUT, expected pushes are
// queued as stimulus is issued and a monitor checks each push for order, route and latency.
module tb_arbitro_vc;

    localparam int DS = 10;

    logic          clk = 1'b0;
    logic          reset_L;
    logic [DS-1:0] data_vc0, data_vc1;
    logic          vc0_empty, vc1_empty;
    logic          d0_pause, d1_pause;
    logic          pop_vc0, pop_vc1, push_d0, push_d1;
    logic [DS-1:0] data_out;
    logic [4:0]    cnt_d0, cnt_d1;
    logic          idle;

    int checks   = 0;
    int failures = 0;
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;

    logic [DS-1:0] vc0_q[$];
    logic [DS-1:0] vc1_q[$];
    logic [DS-1:0] exp_q[$];

    logic [DS-1:0] t3_vc0 [8]  = '{10'h010, 10'h111, 10'h012, 10'h113,
                                   10'h014, 10'h115, 10'h016, 10'h117};
    logic [DS-1:0] t3_vc1 [8]  = '{10'h220, 10'h221, 10'h322, 10'h323,
                                   10'h224, 10'h225, 10'h326, 10'h327};
    logic [DS-1:0] t3_exp [16] = '{10'h010, 10'h111, 10'h012, 10'h113, 10'h220,
                                   10'h014, 10'h115, 10'h016, 10'h117, 10'h221,
                                   10'h322, 10'h323, 10'h224, 10'h225, 10'h326, 10'h327};
    logic [DS-1:0] t6_vc1 [6]  = '{10'h1A1, 10'h0A2, 10'h1A3, 10'h0A4, 10'h0A5, 10'h1A6};

    arbitro_vc #(
        .DATA_SIZE (10),
        .DEST_BIT  (8),
        .STARVE_MAX(4),
        .CNT_W     (5)
    ) dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .data_vc0 (data_vc0),
        .data_vc1 (data_vc1),
        .vc0_empty(vc0_empty),
        .vc1_empty(vc1_empty),
        .d0_pause (d0_pause),
        .d1_pause (d1_pause),
        .pop_vc0  (pop_vc0),
        .pop_vc1  (pop_vc1),
        .push_d0  (push_d0),
        .push_d1  (push_d1),
        .data_out (data_out),
        .cnt_d0   (cnt_d0),
        .cnt_d1   (cnt_d1),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic expect_word(input logic [DS-1:0] w);
        exp_q.push_back(w);
        if (w[8]) exp_cnt1++;
        else exp_cnt0++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset_L = 1'b0;
        vc0_q.delete();
        vc1_q.delete();
        exp_q.delete();
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        #1;
        chk("rst_push_d0", push_d0, 0);
        chk("rst_push_d1", push_d1, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_cnt_d0", cnt_d0, 0);
        chk("rst_cnt_d1", cnt_d1, 0);
        chk("rst_pops", {pop_vc1, pop_vc0}, 0);
        chk("rst_idle", idle, 1);
        repeat (3) @(posedge clk);
        #3;
        reset_L = 1'b1;
    endtask

    task automatic wait_pop(input bit vc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (vc ? pop_vc1 : pop_vc0) ok = 1'b1;
        end
        chk(vc ? "pop_vc1_seen" : "pop_vc0_seen", 32'(ok), 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || !idle) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_idle"}, idle, 1);
        chk({name, "_cnt_d0"}, cnt_d0, exp_cnt0 % 32);
        chk({name, "_cnt_d1"}, cnt_d1, exp_cnt1 % 32);
    endtask

    // VC FIFO model: pops seen during a cycle deliver read data just after the closing edge.
    initial begin : fifo_model
        logic p0, p1;
        data_vc0  = '0;
        data_vc1  = '0;
        vc0_empty = 1'b1;
        vc1_empty = 1'b1;
        forever begin
            @(negedge clk);
            p0 = pop_vc0;
            p1 = pop_vc1;
            if (p0) chk("pop_vc0_nonempty", vc0_empty, 0);
            if (p1) chk("pop_vc1_nonempty", vc1_empty, 0);
            if (p0 || p1) chk("single_pop", 32'(p0 && p1), 0);
            @(posedge clk);
            #1;
            if (p0 && vc0_q.size() > 0) data_vc0 = vc0_q.pop_front();
            if (p1 && vc1_q.size() > 0) data_vc1 = vc1_q.pop_front();
            vc0_empty = (vc0_q.size() == 0);
            vc1_empty = (vc1_q.size() == 0);
        end
    end

    initial begin : monitor
        int cyc = 0;
        int stamps[$];
        logic [DS-1:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_L) begin
                stamps.delete();
            end else begin
                if (pop_vc0 || pop_vc1) stamps.push_back(cyc);
                if (push_d0 || push_d1) begin
                    chk("push_onehot", 32'(push_d0 && push_d1), 0);
                    if (exp_q.size() == 0) begin
                        chk("push_unexpected", {push_d1, push_d0}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("push_data", data_out, e);
                        chk("push_route_d1", push_d1, e[8]);
                    end
                    if (stamps.size() == 0) chk("push_without_pop", cyc, 0);
                    else chk("pop_to_push_latency", cyc, stamps.pop_front() + 2);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : main
        bit ok;
        int npush;
        reset_L  = 1'b0;
        d0_pause = 1'b0;
        d1_pause = 1'b0;
        do_reset();

        // VC0 only, one word per destination
        @(posedge clk);
        #2;
        vc0_q.push_back(10'h005);
        vc0_q.push_back(10'h105);
        expect_word(10'h005);
        expect_word(10'h105);
        drain("vc0_only");

        // Reset one cycle after a pop: the popped word must never be pushed
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) vc0_q.push_back(10'(10'h040 + i));
        wait_pop(1'b0, ok);
        do_reset();
        npush = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (push_d0 || push_d1) npush++;
        end
        chk("rst_mid_no_push", npush, 0);
        chk("rst_mid_idle", idle, 1);

        // Priority with starvation guard
        @(posedge clk);
        #2;
        for (int i = 0; i < 8; i++) begin
            vc0_q.push_back(t3_vc0[i]);
            vc1_q.push_back(t3_vc1[i]);
        end
        for (int i = 0; i < 16; i++) expect_word(t3_exp[i]);
        drain("starve");

        // Pause while VC0 streams
        @(posedge clk);
        #2;
        for (int i = 0; i < 12; i++) begin
            vc0_q.push_back(10'(((i % 2) << 8) | 'h30 | i));
            expect_word(10'(((i % 2) << 8) | 'h30 | i));
        end
        wait_pop(1'b0, ok);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        d1_pause = 1'b1;
        npush = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("pause_pop_vc0", pop_vc0, 0);
            if (push_d0 || push_d1) npush++;
        end
        chk("pause_inflight_le2", 32'(npush <= 2), 1);
        @(posedge clk);
        #2;
        d1_pause = 1'b0;
        @(negedge clk);
        chk("pause_resume", pop_vc0, 1);
        drain("pause");

        // Back-to-back VC1 throughput
        @(posedge clk);
        #2;
        for (int i = 0; i < 6; i++) begin
            vc1_q.push_back(t6_vc1[i]);
            expect_word(t6_vc1[i]);
        end
        wait_pop(1'b1, ok);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("b2b_pop_vc1", pop_vc1, 1);
        end
        @(negedge clk);
        chk("b2b_pop_vc1_end", pop_vc1, 0);
        drain("b2b");

        // Counter wrap: 33 words to D0
        do_reset();
        @(posedge clk);
        #2;
        for (int i = 0; i < 33; i++) begin
            vc0_q.push_back(10'(i));
            expect_word(10'(i));
        end
        drain("wrap");
        chk("wrap_cnt_d0_value", cnt_d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
